// File: rtl/pipeline_interlock_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32I pipeline: load-use interlock,
// data-memory wait freeze and branch/jump redirect squash, plus perf counters.
module pipeline_interlock_ctrl #(
    parameter int MAX_WAIT        = 16,
    parameter int REDIRECT_CYCLES = 2,
    parameter int CNT_W           = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_write_reg,
    input  logic             ex_is_load,
    input  logic             ex_redirect,
    input  logic             mem_req,
    input  logic             mem_ack,
    output logic             stall_fetch,
    output logic             stall_decode,
    output logic             stall_exec,
    output logic             bubble_exec,
    output logic             bubble_wb,
    output logic             flush_fetch,
    output logic             flush_decode,
    output logic [1:0]       state_o,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] redirect_count
);
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        REDIRECT = 2'd2
    } state_t;

    localparam int WW = $clog2(MAX_WAIT + 1);
    localparam int RW = (REDIRECT_CYCLES > 1) ? $clog2(REDIRECT_CYCLES) : 1;
    localparam logic [WW-1:0] WAIT_MAX   = WW'(MAX_WAIT);
    localparam logic [RW-1:0] REDIR_INIT = RW'(REDIRECT_CYCLES - 1);

    state_t            state_q, state_d;
    logic [WW-1:0]     wait_cnt_q, wait_cnt_d;
    logic [RW-1:0]     redir_cnt_q, redir_cnt_d;
    logic              timeout_q, timeout_d;
    logic [CNT_W-1:0]  stall_cycles_q, redirect_count_q;

    logic mem_busy, load_use, resume_run, take_redirect;
    logic sf_c, sd_c, se_c, be_c, bw_c, ff_c, fd_c;

    assign mem_busy = mem_req & ~mem_ack;
    assign load_use = ex_is_load & ex_write_reg & (ex_rd != 5'd0) &
                      ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));

    always_comb begin
        state_d       = RUN;
        wait_cnt_d    = '0;
        redir_cnt_d   = redir_cnt_q;
        timeout_d     = timeout_q;
        resume_run    = 1'b0;
        take_redirect = 1'b0;
        sf_c = 1'b0; sd_c = 1'b0; se_c = 1'b0; be_c = 1'b0;
        bw_c = 1'b0; ff_c = 1'b0; fd_c = 1'b0;

        if (mem_busy) begin
            // Freeze everything up to MEM and drain a NOP into WB.
            sf_c = 1'b1; sd_c = 1'b1; se_c = 1'b1; bw_c = 1'b1;
            state_d    = MEM_WAIT;
            wait_cnt_d = (wait_cnt_q == WAIT_MAX) ? wait_cnt_q : wait_cnt_q + WW'(1);
            if (wait_cnt_d == WAIT_MAX) timeout_d = 1'b1;
        end else begin
            case (state_q)
                RUN: resume_run = 1'b1;
                MEM_WAIT: begin
                    if (redir_cnt_q != '0) state_d = REDIRECT;
                    else                   resume_run = 1'b1;
                end
                REDIRECT: begin
                    if (redir_cnt_q == '0) begin
                        resume_run = 1'b1;
                    end else begin
                        ff_c = 1'b1;
                        if (redir_cnt_q == RW'(1)) begin
                            state_d     = RUN;
                            redir_cnt_d = '0;
                        end else begin
                            state_d     = REDIRECT;
                            redir_cnt_d = redir_cnt_q - RW'(1);
                        end
                    end
                end
                default: state_d = RUN;
            endcase

            // Redirect outranks load-use: the dependent instruction is squashed anyway.
            if (resume_run) begin
                if (ex_redirect) begin
                    ff_c = 1'b1; fd_c = 1'b1;
                    take_redirect = 1'b1;
                    state_d     = (REDIRECT_CYCLES > 1) ? REDIRECT : RUN;
                    redir_cnt_d = REDIR_INIT;
                end else if (load_use) begin
                    sf_c = 1'b1; sd_c = 1'b1; be_c = 1'b1;
                end
            end
        end
    end

    assign stall_fetch    = sf_c & ~reset;
    assign stall_decode   = sd_c & ~reset;
    assign stall_exec     = se_c & ~reset;
    assign bubble_exec    = be_c & ~reset;
    assign bubble_wb      = bw_c & ~reset;
    assign flush_fetch    = ff_c & ~reset;
    assign flush_decode   = fd_c & ~reset;
    assign state_o        = state_q;
    assign mem_timeout    = timeout_q;
    assign stall_cycles   = stall_cycles_q;
    assign redirect_count = redirect_count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= RUN;
            wait_cnt_q       <= '0;
            redir_cnt_q      <= '0;
            timeout_q        <= 1'b0;
            stall_cycles_q   <= '0;
            redirect_count_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            redir_cnt_q <= redir_cnt_d;
            timeout_q   <= timeout_d;
            if (sf_c)          stall_cycles_q   <= stall_cycles_q + CNT_W'(1);
            if (take_redirect) redirect_count_q <= redirect_count_q + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_pipeline_interlock_ctrl.sv
// Self-checking bench for pipeline_interlock_ctrl: per-cycle expected control
// vectors go through a scoreboard queue; counters are checked at test boundaries.
module tb_pipeline_interlock_ctrl;
    localparam int CNT_W = 32;
    localparam logic [9:0] FULL = 10'h3FF;
    localparam logic [9:0] CTL  = 10'h3F8;

    logic clk, reset;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic id_use_rs1, id_use_rs2, ex_write_reg, ex_is_load, ex_redirect, mem_req, mem_ack;
    logic stall_fetch, stall_decode, stall_exec, bubble_exec, bubble_wb;
    logic flush_fetch, flush_decode, mem_timeout;
    logic [1:0] state_o;
    logic [CNT_W-1:0] stall_cycles, redirect_count;

    int err_cnt = 0;
    int chk_cnt = 0;
    int exp_stall = 0;
    int exp_redir = 0;
    logic [9:0] exp_q[$];
    logic [9:0] mask_q[$];
    string      tag_q[$];

    pipeline_interlock_ctrl #(.MAX_WAIT(4), .REDIRECT_CYCLES(2), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_rd(ex_rd), .ex_write_reg(ex_write_reg), .ex_is_load(ex_is_load),
        .ex_redirect(ex_redirect), .mem_req(mem_req), .mem_ack(mem_ack),
        .stall_fetch(stall_fetch), .stall_decode(stall_decode), .stall_exec(stall_exec),
        .bubble_exec(bubble_exec), .bubble_wb(bubble_wb),
        .flush_fetch(flush_fetch), .flush_decode(flush_decode),
        .state_o(state_o), .mem_timeout(mem_timeout),
        .stall_cycles(stall_cycles), .redirect_count(redirect_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Vector layout: sf sd se be bw ff fd state[1:0] timeout
    function automatic logic [9:0] mk(input logic sf, input logic sd, input logic se,
                                      input logic be, input logic bw, input logic ff,
                                      input logic fd, input logic [1:0] st, input logic to);
        return {sf, sd, se, be, bw, ff, fd, st, to};
    endfunction

    task automatic idle();
        id_rs1 = 5'd0; id_rs2 = 5'd0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
        ex_rd = 5'd0; ex_write_reg = 1'b0; ex_is_load = 1'b0; ex_redirect = 1'b0;
        mem_req = 1'b0; mem_ack = 1'b0;
    endtask

    task automatic set_load(input logic [4:0] rd, input logic wr, input logic [4:0] rs1,
                            input logic u1, input logic [4:0] rs2, input logic u2);
        ex_is_load = 1'b1; ex_rd = rd; ex_write_reg = wr;
        id_rs1 = rs1; id_use_rs1 = u1; id_rs2 = rs2; id_use_rs2 = u2;
    endtask

    // Push the expectation for the cycle being driven, then pop and compare mid-cycle.
    task automatic run_cycle(input string tag, input logic [9:0] exp, input logic [9:0] msk);
        logic [9:0] obs, e, m;
        exp_q.push_back(exp);
        mask_q.push_back(msk);
        tag_q.push_back(tag);
        if (exp[9] && !reset) exp_stall++;
        @(negedge clk);
        obs = {stall_fetch, stall_decode, stall_exec, bubble_exec, bubble_wb,
               flush_fetch, flush_decode, state_o, mem_timeout};
        e = exp_q.pop_front();
        m = mask_q.pop_front();
        check_eq(tag_q.pop_front(), {22'd0, obs & m}, {22'd0, e & m});
        @(posedge clk);
        #1;
    endtask

    task automatic check_counters(input string tag);
        check_eq({tag, "_stall_cnt"}, stall_cycles, exp_stall);
        check_eq({tag, "_redir_cnt"}, redirect_count, exp_redir);
    endtask

    initial begin
        logic lu;
        reset = 1'b1;
        idle();
        @(posedge clk);
        #1;
        run_cycle("reset", mk(0,0,0,0,0,0,0,2'd0,0), FULL);
        reset = 1'b0;
        check_counters("after_reset");
        run_cycle("idle", mk(0,0,0,0,0,0,0,2'd0,0), FULL);

        // Load-use on rs1, then the bubble reaches EX
        set_load(5'd5, 1'b1, 5'd5, 1'b1, 5'd0, 1'b0);
        run_cycle("lu_rs1", mk(1,1,0,1,0,0,0,2'd0,0), FULL);
        idle();
        run_cycle("lu_after", mk(0,0,0,0,0,0,0,2'd0,0), FULL);
        check_counters("lu");

        set_load(5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1);
        run_cycle("lu_x0", mk(0,0,0,0,0,0,0,2'd0,0), FULL);
        set_load(5'd5, 1'b1, 5'd5, 1'b0, 5'd5, 1'b0);
        run_cycle("lu_nouse", mk(0,0,0,0,0,0,0,2'd0,0), FULL);
        set_load(5'd7, 1'b0, 5'd7, 1'b1, 5'd0, 1'b0);
        run_cycle("lu_nowrite", mk(0,0,0,0,0,0,0,2'd0,0), FULL);
        set_load(5'd9, 1'b1, 5'd1, 1'b1, 5'd9, 1'b1);
        run_cycle("lu_rs2", mk(1,1,0,1,0,0,0,2'd0,0), FULL);
        idle();
        run_cycle("lu_x0_idle", mk(0,0,0,0,0,0,0,2'd0,0), FULL);
        check_counters("lu_patterns");

        // Random dependency patterns on a small register range to force matches
        for (int i = 0; i < 24; i++) begin
            ex_is_load = 1'($urandom_range(0, 1));
            ex_write_reg = 1'($urandom_range(0, 1));
            ex_rd = 5'($urandom_range(0, 3));
            id_rs1 = 5'($urandom_range(0, 3));
            id_rs2 = 5'($urandom_range(0, 3));
            id_use_rs1 = 1'($urandom_range(0, 1));
            id_use_rs2 = 1'($urandom_range(0, 1));
            lu = ex_is_load && ex_write_reg && (ex_rd != 0) &&
                 ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
            run_cycle("lu_rand", mk(lu,lu,0,lu,0,0,0,2'd0,0), FULL);
        end
        idle();
        check_counters("lu_rand");

        // Single redirect
        ex_redirect = 1'b1;
        run_cycle("redir_c0", mk(0,0,0,0,0,1,1,2'd0,0), FULL);
        exp_redir++;
        ex_redirect = 1'b0;
        run_cycle("redir_c1", mk(0,0,0,0,0,1,0,2'd2,0), FULL);
        run_cycle("redir_c2", mk(0,0,0,0,0,0,0,2'd0,0), FULL);
        check_counters("redir");

        // Three-cycle memory wait
        mem_req = 1'b1;
        run_cycle("mw_c0", mk(1,1,1,0,1,0,0,2'd0,0), FULL);
        run_cycle("mw_c1", mk(1,1,1,0,1,0,0,2'd1,0), FULL);
        run_cycle("mw_c2", mk(1,1,1,0,1,0,0,2'd1,0), FULL);
        mem_ack = 1'b1;
        run_cycle("mw_ack", mk(0,0,0,0,0,0,0,2'd1,0), FULL);
        idle();
        run_cycle("mw_run", mk(0,0,0,0,0,0,0,2'd0,0), FULL);
        check_counters("mw");

        // Timeout with MAX_WAIT=4: flag visible from the 5th busy cycle, sticky
        mem_req = 1'b1;
        run_cycle("to_c0", mk(1,1,1,0,1,0,0,2'd0,0), FULL);
        run_cycle("to_c1", mk(1,1,1,0,1,0,0,2'd1,0), FULL);
        run_cycle("to_c2", mk(1,1,1,0,1,0,0,2'd1,0), FULL);
        run_cycle("to_c3", mk(1,1,1,0,1,0,0,2'd1,0), FULL);
        run_cycle("to_c4", mk(1,1,1,0,1,0,0,2'd1,1), FULL);
        run_cycle("to_c5", mk(1,1,1,0,1,0,0,2'd1,1), FULL);
        mem_ack = 1'b1;
        run_cycle("to_ack", mk(0,0,0,0,0,0,0,2'd1,1), FULL);
        idle();
        run_cycle("to_sticky", mk(0,0,0,0,0,0,0,2'd0,1), FULL);
        check_counters("to");
        reset = 1'b1;
        run_cycle("to_reset", mk(0,0,0,0,0,0,0,2'd0,0), CTL);
        reset = 1'b0;
        exp_stall = 0;
        exp_redir = 0;
        run_cycle("to_cleared", mk(0,0,0,0,0,0,0,2'd0,0), FULL);
        check_counters("to_reset");

        // Memory wait, redirect and load-use together
        mem_req = 1'b1;
        ex_redirect = 1'b1;
        set_load(5'd3, 1'b1, 5'd3, 1'b1, 5'd0, 1'b0);
        run_cycle("sim_c0", mk(1,1,1,0,1,0,0,2'd0,0), FULL);
        run_cycle("sim_c1", mk(1,1,1,0,1,0,0,2'd1,0), FULL);
        mem_ack = 1'b1;
        run_cycle("sim_ack", mk(0,0,0,0,0,1,1,2'd1,0), FULL);
        exp_redir++;
        idle();
        run_cycle("sim_redir", mk(0,0,0,0,0,1,0,2'd2,0), FULL);
        run_cycle("sim_run", mk(0,0,0,0,0,0,0,2'd0,0), FULL);
        check_counters("sim");

        // Memory wait preempting REDIRECT; the remaining flush cycle resumes afterwards
        ex_redirect = 1'b1;
        run_cycle("pre_redir", mk(0,0,0,0,0,1,1,2'd0,0), FULL);
        exp_redir++;
        ex_redirect = 1'b0;
        mem_req = 1'b1;
        run_cycle("pre_busy0", mk(1,1,1,0,1,0,0,2'd2,0), FULL);
        run_cycle("pre_busy1", mk(1,1,1,0,1,0,0,2'd1,0), FULL);
        mem_ack = 1'b1;
        run_cycle("pre_ack", mk(0,0,0,0,0,0,0,2'd1,0), FULL);
        idle();
        run_cycle("pre_resume", mk(0,0,0,0,0,1,0,2'd2,0), FULL);
        run_cycle("pre_run", mk(0,0,0,0,0,0,0,2'd0,0), FULL);
        check_counters("pre");

        // Reset in the middle of REDIRECT
        ex_redirect = 1'b1;
        run_cycle("rr_redir", mk(0,0,0,0,0,1,1,2'd0,0), FULL);
        ex_redirect = 1'b0;
        reset = 1'b1;
        run_cycle("rr_reset", mk(0,0,0,0,0,0,0,2'd0,0), CTL);
        reset = 1'b0;
        exp_stall = 0;
        exp_redir = 0;
        run_cycle("rr_after", mk(0,0,0,0,0,0,0,2'd0,0), FULL);
        check_counters("rr");

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end
endmodule
